// File: rtl/bus_demux16_reg_pkg.sv
// Shared widths, slot-index type and action encoding for the registered 1-to-16 bus demux.
package bus_demux16_reg_pkg;

  localparam int unsigned SEL_W     = 4;
  localparam int unsigned NUM_SLOTS = 16;
  localparam int unsigned CNT_W     = 5;

  typedef logic [SEL_W-1:0] slot_idx_t;

  // One action per edge, resolved by priority clr > bcast > wr_en > idle.
  typedef enum logic [1:0] {
    ACT_IDLE  = 2'd0,
    ACT_CLR   = 2'd1,
    ACT_BCAST = 2'd2,
    ACT_WR    = 2'd3
  } action_e;

  // Auto-increment pointer step; natural 4-bit wrap from 15 to 0.
  function automatic slot_idx_t ptr_inc(input slot_idx_t p);
    return p + SEL_W'(1);
  endfunction

endpackage

// File: rtl/bus_demux16_reg_decoder4to16.sv
// Combinational 4-bit slot index to 16-bit one-hot write enable.
module decoder4to16
  import bus_demux16_reg_pkg::*;
(
  input  logic                 en,
  input  slot_idx_t            idx,
  output logic [NUM_SLOTS-1:0] onehot_c
);

  always_comb begin
    onehot_c = '0;
    if (en) begin
      onehot_c[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_demux16_reg.sv
// Registered 1-to-16 bus demultiplexer: steers d_in into one of 16 held slots by
// explicit select or auto-incrementing pointer, with valid flags, fill count and write ack.
module bus_demux16_reg
  import bus_demux16_reg_pkg::*;
#(
  parameter int unsigned DataSize = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DataSize-1:0]           d_in,
  input  logic [SEL_W-1:0]              sel,
  input  logic                          wr_en,
  input  logic                          auto_inc,
  input  logic                          bcast,
  input  logic                          clr,
  output logic [NUM_SLOTS*DataSize-1:0] q,
  output logic [NUM_SLOTS-1:0]          slot_valid,
  output logic [SEL_W-1:0]              ptr,
  output logic [CNT_W-1:0]              fill_cnt,
  output logic                          full,
  output logic                          wr_ack,
  output logic [SEL_W-1:0]              ack_idx
);

  logic [NUM_SLOTS-1:0][DataSize-1:0] slot_r;
  logic [NUM_SLOTS-1:0][DataSize-1:0] slot_nxt;
  logic [NUM_SLOTS-1:0]               valid_nxt;
  logic [SEL_W-1:0]                   ptr_nxt;
  logic [CNT_W-1:0]                   cnt_nxt;
  logic                               full_nxt;
  logic                               ack_nxt;
  logic [SEL_W-1:0]                   ack_idx_nxt;

  action_e                            act_c;
  slot_idx_t                          tgt_c;
  logic [NUM_SLOTS-1:0]               dec_c;
  logic [NUM_SLOTS-1:0]               load_en_c;

  assign q = slot_r;

  // Resolve the single action taken at this edge.
  always_comb begin
    act_c = ACT_IDLE;
    if (clr) begin
      act_c = ACT_CLR;
    end else if (bcast) begin
      act_c = ACT_BCAST;
    end else if (wr_en) begin
      act_c = ACT_WR;
    end
  end

  assign tgt_c = auto_inc ? slot_idx_t'(ptr) : slot_idx_t'(sel);

  decoder4to16 u_dec (
    .en       (act_c == ACT_WR),
    .idx      (tgt_c),
    .onehot_c (dec_c)
  );

  assign load_en_c = dec_c | {NUM_SLOTS{act_c == ACT_BCAST}};

  // Next-state for slots, flags, pointer, count and acknowledge.
  always_comb begin
    slot_nxt    = slot_r;
    valid_nxt   = slot_valid;
    ptr_nxt     = ptr;
    cnt_nxt     = fill_cnt;
    ack_nxt     = 1'b0;
    ack_idx_nxt = ack_idx;

    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      if (load_en_c[k]) begin
        slot_nxt[k] = d_in;
      end
    end

    case (act_c)
      ACT_CLR: begin
        slot_nxt  = '0;
        valid_nxt = '0;
        ptr_nxt   = '0;
        cnt_nxt   = '0;
      end
      ACT_BCAST: begin
        valid_nxt   = '1;
        cnt_nxt     = CNT_W'(NUM_SLOTS);
        ack_nxt     = 1'b1;
        ack_idx_nxt = '0;
      end
      ACT_WR: begin
        valid_nxt = slot_valid | dec_c;
        // Count only invalid-to-valid transitions, so it tops out at 16.
        if (!slot_valid[tgt_c]) begin
          cnt_nxt = fill_cnt + CNT_W'(1);
        end
        if (auto_inc) begin
          ptr_nxt = ptr_inc(ptr);
        end
        ack_nxt     = 1'b1;
        ack_idx_nxt = tgt_c;
      end
      default: begin
      end
    endcase

    full_nxt = (cnt_nxt == CNT_W'(NUM_SLOTS));
  end

  // State register; full is registered alongside the count it reflects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r     <= '0;
      slot_valid <= '0;
      ptr        <= '0;
      fill_cnt   <= '0;
      full       <= 1'b0;
      wr_ack     <= 1'b0;
      ack_idx    <= '0;
    end else begin
      slot_r     <= slot_nxt;
      slot_valid <= valid_nxt;
      ptr        <= ptr_nxt;
      fill_cnt   <= cnt_nxt;
      full       <= full_nxt;
      wr_ack     <= ack_nxt;
      ack_idx    <= ack_idx_nxt;
    end
  end

endmodule

// File: tb/tb_bus_demux16_reg.sv
// Self-checking bench for bus_demux16_reg: directed steps plus random traffic
// compared against a slot-array reference model.
module tb_bus_demux16_reg;

  localparam int unsigned DW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DW-1:0]   d_in;
  logic [3:0]      sel;
  logic            wr_en;
  logic            auto_inc;
  logic            bcast;
  logic            clr;
  logic [16*DW-1:0] q;
  logic [15:0]     slot_valid;
  logic [3:0]      ptr;
  logic [4:0]      fill_cnt;
  logic            full;
  logic            wr_ack;
  logic [3:0]      ack_idx;

  int errors = 0;
  int checks = 0;

  int m_slot[16];
  bit m_val[16];
  int m_ptr;
  bit m_ack;
  int m_ackidx;

  bus_demux16_reg #(.DataSize(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_in       (d_in),
    .sel        (sel),
    .wr_en      (wr_en),
    .auto_inc   (auto_inc),
    .bcast      (bcast),
    .clr        (clr),
    .q          (q),
    .slot_valid (slot_valid),
    .ptr        (ptr),
    .fill_cnt   (fill_cnt),
    .full       (full),
    .wr_ack     (wr_ack),
    .ack_idx    (ack_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      m_slot[k] = 0;
      m_val[k]  = 1'b0;
    end
    m_ptr    = 0;
    m_ack    = 1'b0;
    m_ackidx = 0;
  endtask

  task automatic model_step(input bit c, input bit b, input bit w, input bit a,
                            input int s, input int d);
    int t;
    m_ack = 1'b0;
    if (c) begin
      for (int k = 0; k < 16; k++) begin
        m_slot[k] = 0;
        m_val[k]  = 1'b0;
      end
      m_ptr = 0;
    end else if (b) begin
      for (int k = 0; k < 16; k++) begin
        m_slot[k] = d;
        m_val[k]  = 1'b1;
      end
      m_ack    = 1'b1;
      m_ackidx = 0;
    end else if (w) begin
      t = a ? m_ptr : s;
      m_slot[t] = d;
      m_val[t]  = 1'b1;
      if (a) m_ptr = (m_ptr + 1) % 16;
      m_ack    = 1'b1;
      m_ackidx = t;
    end
  endtask

  task automatic check_all(input string tag);
    logic [16*DW-1:0] eq;
    logic [15:0]      ev;
    int               cnt;
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      eq[k*DW +: DW] = DW'(m_slot[k]);
      ev[k]          = m_val[k];
      cnt           += int'(m_val[k]);
    end
    check({tag, ":q"},          64'(q),          64'(eq));
    check({tag, ":slot_valid"}, 64'(slot_valid), 64'(ev));
    check({tag, ":ptr"},        64'(ptr),        64'(m_ptr));
    check({tag, ":fill_cnt"},   64'(fill_cnt),   64'(cnt));
    check({tag, ":full"},       64'(full),       64'(cnt == 16));
    check({tag, ":wr_ack"},     64'(wr_ack),     64'(m_ack));
    check({tag, ":ack_idx"},    64'(ack_idx),    64'(m_ackidx));
  endtask

  task automatic cycle(input string tag, input bit c, input bit b, input bit w,
                       input bit a, input int s, input int d);
    @(negedge clk);
    clr      = c;
    bcast    = b;
    wr_en    = w;
    auto_inc = a;
    sel      = 4'(s);
    d_in     = DW'(d);
    @(posedge clk);
    model_step(c, b, w, a, s % 16, d % 4);
    #1 check_all(tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    d_in     = '0;
    sel      = '0;
    wr_en    = 1'b0;
    auto_inc = 1'b0;
    bcast    = 1'b0;
    clr      = 1'b0;
    model_reset();

    // Reset state
    #12 check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: explicit write to slot 5
    cycle("t1", 0, 0, 1, 0, 5, 3);
    check("t1_slot5", 64'(q[5*DW +: DW]), 64'd3);
    check("t1_valid", 64'(slot_valid), 64'h0020);
    check("t1_ackidx", 64'(ack_idx), 64'd5);
    cycle("t1_idle", 0, 0, 0, 0, 0, 0);

    // 2: 17 auto-increment writes, wrap and overwrite when full
    cycle("t2_clr", 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 17; k++) begin
      cycle("t2_auto", 0, 0, 1, 1, 0, k % 4);
      check("t2_ackidx_seq", 64'(ack_idx), 64'(k % 16));
    end
    check("t2_full", 64'(full), 64'd1);
    check("t2_cnt", 64'(fill_cnt), 64'd16);

    // 3: rewrite sel=5 twice
    cycle("t3_clr", 1, 0, 0, 0, 0, 0);
    cycle("t3_w1", 0, 0, 1, 0, 5, 1);
    cycle("t3_w2", 0, 0, 1, 0, 5, 2);
    check("t3_cnt", 64'(fill_cnt), 64'd1);
    check("t3_slot5", 64'(q[5*DW +: DW]), 64'd2);

    // 4: clr wins over bcast and wr_en, then bcast alone
    cycle("t4_pre", 0, 0, 1, 1, 9, 3);
    cycle("t4_all", 1, 1, 1, 1, 9, 3);
    check("t4_noack", 64'(wr_ack), 64'd0);
    cycle("t4_bcast", 0, 1, 0, 0, 7, 2);
    check("t4_q", 64'(q), 64'hAAAA_AAAA);

    // 5: asynchronous reset between edges with wr_en held
    @(negedge clk);
    clr = 1'b0; bcast = 1'b0; wr_en = 1'b1; auto_inc = 1'b0; sel = 4'd7; d_in = 2'd3;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("t5_async");
    @(posedge clk);
    #1 check_all("t5_hold");
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_all("t5_release");

    // 6: pointer with interleaved explicit write
    cycle("t6_clr", 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle("t6_auto", 0, 0, 1, 1, 0, k + 1);
    cycle("t6_expl", 0, 0, 1, 0, 12, 3);
    cycle("t6_auto4", 0, 0, 1, 1, 0, 2);
    check("t6_ackidx", 64'(ack_idx), 64'd3);
    check("t6_ptr", 64'(ptr), 64'd4);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 63));
      cycle("rand", r == 0, (r == 1) || (r == 2), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
